// File: rtl/video_frame_sanitizer.sv
// Re-frames a raw AXI4-Stream video feed into fixed FRAME_RES_X x FRAME_RES_Y frames
// by padding short lines/frames, truncating long lines and discarding pre-SOF beats.
module video_frame_sanitizer #(
  parameter int                     TDATA_WIDTH = 16,
  parameter int                     FRAME_RES_X = 1920,
  parameter int                     FRAME_RES_Y = 1080,
  parameter logic [TDATA_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     video_i_tvalid,
  output logic                     video_i_tready,
  input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
  input  logic [TDATA_WIDTH/8-1:0] video_i_tstrb,
  input  logic [TDATA_WIDTH/8-1:0] video_i_tkeep,
  input  logic                     video_i_tlast,
  input  logic                     video_i_tid,
  input  logic                     video_i_tdest,
  input  logic                     video_i_tuser,
  output logic                     video_o_tvalid,
  input  logic                     video_o_tready,
  output logic [TDATA_WIDTH-1:0]   video_o_tdata,
  output logic [TDATA_WIDTH/8-1:0] video_o_tstrb,
  output logic [TDATA_WIDTH/8-1:0] video_o_tkeep,
  output logic                     video_o_tlast,
  output logic                     video_o_tid,
  output logic                     video_o_tdest,
  output logic                     video_o_tuser,
  output logic                     pad_o,
  output logic                     trunc_o
);

  localparam int SW = TDATA_WIDTH / 8;
  localparam int XW = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int YW = (FRAME_RES_Y > 1) ? $clog2(FRAME_RES_Y) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(FRAME_RES_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FRAME_RES_Y - 1);

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    PAD_LINE,
    PAD_FRAME,
    DROP
  } state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;
  logic            pad_reg, pad_next;
  logic            trunc_reg, trunc_next;
  logic            last_tid_reg, last_tdest_reg;

  logic                   o_tvalid_reg;
  logic [TDATA_WIDTH-1:0] o_tdata_reg;
  logic [SW-1:0]          o_tstrb_reg, o_tkeep_reg;
  logic                   o_tlast_reg, o_tid_reg, o_tdest_reg, o_tuser_reg;

  logic load_en;
  logic x_at_max, y_at_max, at_origin, frame_end, early_sof;
  logic in_ready, in_hs;
  logic emit, emit_pad, beat_valid;

  logic [TDATA_WIDTH-1:0] beat_data;
  logic [SW-1:0]          beat_strb, beat_keep;
  logic                   beat_id, beat_dest;

  assign load_en   = !o_tvalid_reg | video_o_tready;
  assign x_at_max  = (x_reg == X_MAX);
  assign y_at_max  = (y_reg == Y_MAX);
  assign at_origin = (x_reg == '0) && (y_reg == '0);
  assign frame_end = x_at_max & y_at_max;
  assign early_sof = video_i_tvalid & video_i_tuser & !at_origin;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    emit       = 1'b0;
    emit_pad   = 1'b0;
    pad_next   = 1'b0;
    trunc_next = 1'b0;
    case (state_reg)
      WAIT_SOF: begin
        // Junk ahead of the first SOF is swallowed; the SOF beat waits for room.
        in_ready = (video_i_tvalid & video_i_tuser) ? load_en : 1'b1;
        if (video_i_tvalid & video_i_tuser & load_en) begin
          emit       = 1'b1;
          state_next = PASS;
        end
      end
      PASS: begin
        if (early_sof) begin
          pad_next   = 1'b1;
          state_next = PAD_FRAME;
        end else begin
          in_ready = load_en;
          if (video_i_tvalid & load_en) begin
            emit = 1'b1;
            if (video_i_tlast & !x_at_max) begin
              pad_next   = 1'b1;
              state_next = PAD_LINE;
            end else if (!video_i_tlast & x_at_max) begin
              trunc_next = 1'b1;
              state_next = DROP;
            end else if (frame_end) begin
              state_next = WAIT_SOF;
            end
          end
        end
      end
      PAD_LINE: begin
        if (load_en) begin
          emit_pad = 1'b1;
          if (x_at_max) state_next = y_at_max ? WAIT_SOF : PASS;
        end
      end
      PAD_FRAME: begin
        if (load_en) begin
          emit_pad = 1'b1;
          if (frame_end) state_next = WAIT_SOF;
        end
      end
      DROP: begin
        // Counters sit at the origin here only when the truncated line closed the frame.
        if (video_i_tvalid & video_i_tuser) begin
          pad_next   = !at_origin;
          state_next = at_origin ? WAIT_SOF : PAD_FRAME;
        end else begin
          in_ready = 1'b1;
          if (video_i_tvalid & video_i_tlast) state_next = at_origin ? WAIT_SOF : PASS;
        end
      end
      default: state_next = WAIT_SOF;
    endcase
  end

  assign beat_valid = emit | emit_pad;
  assign in_hs      = video_i_tvalid & in_ready;

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (beat_valid) begin
      if (x_at_max) begin
        x_next = '0;
        y_next = y_at_max ? '0 : y_reg + 1'b1;
      end else begin
        x_next = x_reg + 1'b1;
      end
    end
  end

  assign beat_data = emit_pad ? PAD_VALUE : video_i_tdata;
  assign beat_id   = emit_pad ? last_tid_reg : video_i_tid;
  assign beat_dest = emit_pad ? last_tdest_reg : video_i_tdest;

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_lane
      assign beat_strb[gi] = emit_pad | video_i_tstrb[gi];
      assign beat_keep[gi] = emit_pad | video_i_tkeep[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= WAIT_SOF;
      x_reg          <= '0;
      y_reg          <= '0;
      pad_reg        <= 1'b0;
      trunc_reg      <= 1'b0;
      last_tid_reg   <= 1'b0;
      last_tdest_reg <= 1'b0;
      o_tvalid_reg   <= 1'b0;
      o_tdata_reg    <= '0;
      o_tstrb_reg    <= '0;
      o_tkeep_reg    <= '0;
      o_tlast_reg    <= 1'b0;
      o_tid_reg      <= 1'b0;
      o_tdest_reg    <= 1'b0;
      o_tuser_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      pad_reg   <= pad_next;
      trunc_reg <= trunc_next;
      if (in_hs) begin
        last_tid_reg   <= video_i_tid;
        last_tdest_reg <= video_i_tdest;
      end
      if (load_en) begin
        o_tvalid_reg <= beat_valid;
        if (beat_valid) begin
          o_tdata_reg <= beat_data;
          o_tstrb_reg <= beat_strb;
          o_tkeep_reg <= beat_keep;
          o_tid_reg   <= beat_id;
          o_tdest_reg <= beat_dest;
          o_tuser_reg <= at_origin;
          o_tlast_reg <= x_at_max;
        end
      end
    end
  end

  // Ready is held low for the whole reset interval, not just after the first edge.
  assign video_i_tready = in_ready & !rst_i;

  assign video_o_tvalid = o_tvalid_reg;
  assign video_o_tdata  = o_tdata_reg;
  assign video_o_tstrb  = o_tstrb_reg;
  assign video_o_tkeep  = o_tkeep_reg;
  assign video_o_tlast  = o_tlast_reg;
  assign video_o_tid    = o_tid_reg;
  assign video_o_tdest  = o_tdest_reg;
  assign video_o_tuser  = o_tuser_reg;
  assign pad_o          = pad_reg;
  assign trunc_o        = trunc_reg;

endmodule

// File: tb/tb_video_frame_sanitizer.sv
// Bench for video_frame_sanitizer: directed and random streams compared against a
// beat-sequence reference model, with random back-pressure and a mid-frame reset.
module tb_video_frame_sanitizer;

  localparam int TDW = 16;
  localparam int SW  = TDW / 8;
  localparam int RX  = 4;
  localparam int RY  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           video_i_tvalid, video_i_tready;
  logic [TDW-1:0] video_i_tdata;
  logic [SW-1:0]  video_i_tstrb, video_i_tkeep;
  logic           video_i_tlast, video_i_tid, video_i_tdest, video_i_tuser;
  logic           video_o_tvalid, video_o_tready;
  logic [TDW-1:0] video_o_tdata;
  logic [SW-1:0]  video_o_tstrb, video_o_tkeep;
  logic           video_o_tlast, video_o_tid, video_o_tdest, video_o_tuser;
  logic           pad_o, trunc_o;

  always #5 clk = ~clk;

  video_frame_sanitizer #(
    .TDATA_WIDTH(TDW), .FRAME_RES_X(RX), .FRAME_RES_Y(RY), .PAD_VALUE(16'h0000)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .video_i_tvalid(video_i_tvalid), .video_i_tready(video_i_tready),
    .video_i_tdata(video_i_tdata), .video_i_tstrb(video_i_tstrb),
    .video_i_tkeep(video_i_tkeep), .video_i_tlast(video_i_tlast),
    .video_i_tid(video_i_tid), .video_i_tdest(video_i_tdest),
    .video_i_tuser(video_i_tuser),
    .video_o_tvalid(video_o_tvalid), .video_o_tready(video_o_tready),
    .video_o_tdata(video_o_tdata), .video_o_tstrb(video_o_tstrb),
    .video_o_tkeep(video_o_tkeep), .video_o_tlast(video_o_tlast),
    .video_o_tid(video_o_tid), .video_o_tdest(video_o_tdest),
    .video_o_tuser(video_o_tuser),
    .pad_o(pad_o), .trunc_o(trunc_o)
  );

  typedef struct {
    logic [TDW-1:0] data;
    logic [SW-1:0]  strb;
    logic [SW-1:0]  keep;
    logic           last;
    logic           id;
    logic           dest;
    logic           user;
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    exp_pad, exp_trunc;

  // Reference model state: position of the next output pixel and stream status.
  int    m_x, m_y;
  bit    m_in_frame, m_drop;
  logic  m_lid, m_ldest;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_in_frame = 0; m_drop = 0; m_lid = 0; m_ldest = 0;
  endtask

  task automatic push_out(logic [TDW-1:0] d, logic [SW-1:0] s, logic [SW-1:0] k,
                          logic id, logic dest);
    beat_t o;
    o.data = d; o.strb = s; o.keep = k; o.id = id; o.dest = dest;
    o.user = (m_x == 0 && m_y == 0);
    o.last = (m_x == RX - 1);
    exp_q.push_back(o);
    if (m_x == RX - 1) begin
      m_x = 0;
      if (m_y == RY - 1) begin m_y = 0; m_in_frame = 0; end
      else m_y++;
    end else begin
      m_x++;
    end
  endtask

  // Turns the offered input beat sequence into the exact output beat sequence.
  task automatic model_run();
    int    i = 0;
    beat_t b;
    bit    end_col;
    exp_q.delete(); exp_pad = 0; exp_trunc = 0;
    while (i < in_q.size()) begin
      b = in_q[i];
      if (m_in_frame && b.user) begin
        exp_pad++;
        while (m_in_frame) push_out('0, {SW{1'b1}}, {SW{1'b1}}, m_lid, m_ldest);
      end else begin
        i++;
        m_lid = b.id; m_ldest = b.dest;
        if (!m_in_frame) begin
          if (b.user) begin
            m_in_frame = 1; m_drop = 0;
            push_out(b.data, b.strb, b.keep, b.id, b.dest);
          end
        end else if (m_drop) begin
          if (b.last) m_drop = 0;
        end else begin
          end_col = (m_x == RX - 1);
          push_out(b.data, b.strb, b.keep, b.id, b.dest);
          if (end_col && !b.last) begin
            exp_trunc++; m_drop = 1;
          end else if (!end_col && b.last) begin
            exp_pad++;
            while (m_x != 0) push_out('0, {SW{1'b1}}, {SW{1'b1}}, m_lid, m_ldest);
          end
        end
      end
    end
  endtask

  task automatic add(logic [TDW-1:0] d, logic last, logic user);
    beat_t b;
    b.data = d; b.strb = SW'($urandom); b.keep = SW'($urandom);
    b.id = 1'($urandom); b.dest = 1'($urandom);
    b.last = last; b.user = user;
    in_q.push_back(b);
  endtask

  task automatic gen_random(int frames);
    int lines, len;
    for (int f = 0; f < frames; f++) begin
      for (int j = 0; j < $urandom_range(2); j++) add(TDW'($urandom), 1'($urandom), 1'b0);
      lines = $urandom_range(1, 3);
      for (int l = 0; l < lines; l++) begin
        len = $urandom_range(1, 6);
        if (l == 0 && len < 2) len = 2;
        for (int p = 0; p < len; p++) add(TDW'($urandom), p == len - 1, l == 0 && p == 0);
      end
    end
  endtask

  function automatic logic [24:0] out_vec();
    return {video_o_tvalid, video_o_tdata, video_o_tstrb, video_o_tkeep,
            video_o_tlast, video_o_tuser, video_o_tid, video_o_tdest};
  endfunction

  task automatic run_case(string name, int vpct, int rpct, int abort_at, bit lat_chk);
    int          cyc = 0, in_idx = 0, out_idx = 0, pads = 0, truncs = 0, idle = 0;
    int          in_cyc[$];
    bit          holding = 0, prev_stall = 0, done = 0;
    logic [24:0] snap = '0, cur;
    beat_t       e;
    model_run();
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && cyc >= abort_at && video_o_tvalid === 1'b1) begin
        video_i_tvalid = 0; video_o_tready = 0;
        #2 rst = 1;
        #1;
        check({name, "_rst_tvalid"}, video_o_tvalid, 0);
        check({name, "_rst_tready"}, video_i_tready, 0);
        check({name, "_rst_tdata"}, video_o_tdata, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        $display("%s: reset applied at cycle %0d after %0d outputs", name, cyc, out_idx);
        return;
      end
      if (!holding) begin
        if (in_idx < in_q.size() && $urandom_range(99) < vpct) begin
          video_i_tvalid = 1;
          video_i_tdata = in_q[in_idx].data; video_i_tstrb = in_q[in_idx].strb;
          video_i_tkeep = in_q[in_idx].keep; video_i_tlast = in_q[in_idx].last;
          video_i_tid = in_q[in_idx].id; video_i_tdest = in_q[in_idx].dest;
          video_i_tuser = in_q[in_idx].user;
          holding = 1;
        end else begin
          video_i_tvalid = 0;
        end
      end
      video_o_tready = ($urandom_range(99) < rpct);
      #1;
      pads   += int'(pad_o);
      truncs += int'(trunc_o);
      cur = out_vec();
      if (prev_stall) check($sformatf("%s_stall_c%0d", name, cyc), cur, snap);
      if (video_o_tvalid && video_o_tready) begin
        if (out_idx < exp_q.size()) begin
          e = exp_q[out_idx];
          check($sformatf("%s_beat%0d", name, out_idx),
                {video_o_tdata, video_o_tstrb, video_o_tkeep, video_o_tlast,
                 video_o_tuser, video_o_tid, video_o_tdest},
                {e.data, e.strb, e.keep, e.last, e.user, e.id, e.dest});
          if (lat_chk && out_idx < in_cyc.size())
            check($sformatf("%s_lat%0d", name, out_idx), cyc, in_cyc[out_idx] + 1);
          $display("%s out[%0d] data=%04h user=%0d last=%0d", name, out_idx,
                   video_o_tdata, video_o_tuser, video_o_tlast);
          out_idx++;
        end else begin
          check({name, "_extra_beat"}, video_o_tvalid, 0);
        end
      end
      if (video_i_tvalid && video_i_tready) begin
        in_idx++; holding = 0; in_cyc.push_back(cyc);
      end
      prev_stall = video_o_tvalid && !video_o_tready;
      snap = cur;
      if (in_idx == in_q.size() && out_idx == exp_q.size()) idle++;
      if (idle >= 8 || cyc > 4000) done = 1;
    end
    video_i_tvalid = 0;
    check({name, "_in_consumed"}, in_idx, in_q.size());
    check({name, "_out_count"}, out_idx, exp_q.size());
    check({name, "_pad_pulses"}, pads, exp_pad);
    check({name, "_trunc_pulses"}, truncs, exp_trunc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    video_i_tvalid = 0; video_i_tdata = '0; video_i_tstrb = '0; video_i_tkeep = '0;
    video_i_tlast = 0; video_i_tid = 0; video_i_tdest = 0; video_i_tuser = 0;
    video_o_tready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tvalid", video_o_tvalid, 0);
    check("reset_tready", video_i_tready, 0);
    check("reset_out", out_vec(), 0);
    check("reset_pulses", {pad_o, trunc_o}, 0);
    rst = 0;
    #1;
    check("idle_tready", video_i_tready, 1);

    // Two clean frames at full throughput.
    in_q.delete();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 8; p++) add(16'h1000 + 16'(f * 8 + p), p % 4 == 3, p == 0);
    run_case("clean", 100, 100, 0, 1);

    // Junk ahead of SOF.
    in_q.delete();
    add(16'hdead, 0, 0); add(16'hbeef, 1, 0); add(16'hcafe, 0, 0);
    for (int p = 0; p < 8; p++) add(16'h2000 + 16'(p), p % 4 == 3, p == 0);
    run_case("junk", 100, 100, 0, 0);

    // Short line 0 of two pixels.
    in_q.delete();
    add(16'h00a1, 0, 1); add(16'h00b2, 1, 0);
    for (int p = 0; p < 4; p++) add(16'h3000 + 16'(p), p == 3, 0);
    run_case("short_line", 100, 100, 0, 0);

    // Long line 0 of six pixels.
    in_q.delete();
    for (int p = 0; p < 6; p++) add(16'h4000 + 16'(p), p == 5, p == 0);
    for (int p = 0; p < 4; p++) add(16'h4100 + 16'(p), p == 3, 0);
    run_case("long_line", 100, 100, 0, 0);

    // Early SOF after five pixels, then a complete frame.
    in_q.delete();
    for (int p = 0; p < 5; p++) add(16'h5000 + 16'(p), p == 3, p == 0);
    for (int p = 0; p < 8; p++) add(16'h5100 + 16'(p), p % 4 == 3, p == 0);
    run_case("early_sof", 100, 100, 0, 0);

    // Random streams under random back-pressure.
    for (int r = 0; r < 4; r++) begin
      in_q.delete();
      gen_random(8);
      run_case($sformatf("rand%0d", r), 70, 50, 0, 0);
    end

    // Reset mid-frame, then resume at the next SOF.
    in_q.delete();
    for (int p = 0; p < 16; p++) add(16'h6000 + 16'(p), p % 4 == 3, p % 8 == 0);
    run_case("abort", 100, 50, 6, 0);
    in_q.delete();
    add(16'h7777, 1, 0); add(16'h7778, 0, 0);
    for (int p = 0; p < 8; p++) add(16'h7000 + 16'(p), p % 4 == 3, p == 0);
    run_case("resume", 80, 60, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
